// File: rtl/id_hazard_unit.sv
// id_hazard_unit
//   Load-use hazard detection and branch flush control for the ID stage.
//   A shadow copy of the ID/EX control fields (valid, load, rd) is kept so
//   that the instruction in ID can be compared against the load in EX.
//   On a hazard PC and IF/ID are frozen and ID/EX receives a bubble for
//   STALL_CYCLES cycles; a taken branch in MEM flushes IF/ID, ID/EX, EX/MEM.
//
// Parameters
//   STALL_CYCLES  bubbles per load-use hazard (1..7)
//
// Ports
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   id_valid              ID holds a real instruction
//   id_rn, id_rm          source registers, id_uses_rn/id_uses_rm qualify them
//   id_mem_read           ID instruction is a load
//   id_reg_write          ID instruction writes id_rd
//   id_rd                 ID destination register
//   branch_taken          branch in MEM resolved taken this cycle
//   pc_write, ifid_write  load enables for PC and IF/ID
//   id_bubble             zero ID/EX control inputs this edge
//   ifid_flush            clear IF/ID valid this edge
//   exmem_flush           zero EX/MEM control fields this edge
//   stall_count           stall cycles seen, saturating
//   flush_count           taken-branch flushes seen, saturating
//
// Build option
//   HAZARD_STATS_EN  when defined, stall_count/flush_count are real
//                    saturating counters; otherwise both read 16'h0000.

module id_hazard_unit #(
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic        id_mem_read,
    input  logic        id_reg_write,
    input  logic [4:0]  id_rd,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        id_bubble,
    output logic        ifid_flush,
    output logic        exmem_flush,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);
    localparam logic [4:0] XZR        = 5'd31;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ex_valid_q, ex_valid_d;
    logic       ex_mem_read_q, ex_mem_read_d;
    logic [4:0] ex_rd_q, ex_rd_d;

    logic hazard;
    logic stall_act;
    logic flush_act;

    // XZR is hard-wired zero, so a load targeting it never creates a dependency.
    always_comb begin
        hazard = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != XZR) &&
                 ((id_uses_rn && (id_rn == ex_rd_q)) ||
                  (id_uses_rm && (id_rm == ex_rd_q)));
    end

    // The first stall cycle is issued from RUN; STALL covers the remaining
    // STALL_CYCLES-1 cycles, so cnt holds the number of stall cycles left.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_act = 1'b0;
        flush_act = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    flush_act = 1'b1;
                end else if (hazard) begin
                    stall_act = 1'b1;
                    cnt_d     = STALL_INIT;
                    state_d   = (STALL_INIT != 3'd0) ? ST_STALL : ST_RUN;
                end
            end
            ST_STALL: begin
                if (branch_taken) begin
                    flush_act = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RUN;
                end else begin
                    stall_act = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        if (RESET) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            id_bubble   = 1'b0;
            ifid_flush  = 1'b0;
            exmem_flush = 1'b0;
        end else begin
            pc_write    = !stall_act;
            ifid_write  = !stall_act;
            id_bubble   = stall_act || flush_act;
            ifid_flush  = flush_act;
            exmem_flush = flush_act;
        end
    end

    // Shadow of what ID/EX captures; a bubble or flush leaves EX empty so the
    // stalled instruction cannot retrigger against the same load.
    always_comb begin
        ex_rd_d = ex_rd_q;
        if (id_bubble || branch_taken) begin
            ex_valid_d    = 1'b0;
            ex_mem_read_d = 1'b0;
        end else begin
            ex_valid_d    = id_valid;
            ex_mem_read_d = id_mem_read && id_reg_write;
            ex_rd_d       = id_rd;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            ex_valid_q    <= 1'b0;
            ex_mem_read_q <= 1'b0;
            ex_rd_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ex_valid_q    <= ex_valid_d;
            ex_mem_read_q <= ex_mem_read_d;
            ex_rd_q       <= ex_rd_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_act && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit: three instances (STALL_CYCLES 1, 3, 7)
// share one stimulus stream; outputs are packed as
// {pc_write, ifid_write, id_bubble, ifid_flush, exmem_flush}.

module tb_id_hazard_unit;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_FLUSH = 5'b11111;

    logic       CLK;
    logic       RESET;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_uses_rn;
    logic       id_uses_rm;
    logic       id_mem_read;
    logic       id_reg_write;
    logic [4:0] id_rd;
    logic       branch_taken;

    logic        pcw1, ifw1, bub1, iff1, exf1;
    logic        pcw3, ifw3, bub3, iff3, exf3;
    logic        pcw7, ifw7, bub7, iff7, exf7;
    logic [15:0] sc1, fc1, sc3, fc3, sc7, fc7;
    logic [4:0]  o1, o3, o7;

    int n_checks = 0;
    int n_errors = 0;

    assign o1 = {pcw1, ifw1, bub1, iff1, exf1};
    assign o3 = {pcw3, ifw3, bub3, iff3, exf3};
    assign o7 = {pcw7, ifw7, bub7, iff7, exf7};

    id_hazard_unit #(.STALL_CYCLES(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_rd(id_rd), .branch_taken(branch_taken),
        .pc_write(pcw1), .ifid_write(ifw1), .id_bubble(bub1), .ifid_flush(iff1),
        .exmem_flush(exf1), .stall_count(sc1), .flush_count(fc1)
    );

    id_hazard_unit #(.STALL_CYCLES(3)) u_dut3 (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_rd(id_rd), .branch_taken(branch_taken),
        .pc_write(pcw3), .ifid_write(ifw3), .id_bubble(bub3), .ifid_flush(iff3),
        .exmem_flush(exf3), .stall_count(sc3), .flush_count(fc3)
    );

    id_hazard_unit #(.STALL_CYCLES(7)) u_dut7 (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .id_rd(id_rd), .branch_taken(branch_taken),
        .pc_write(pcw7), .ifid_write(ifw7), .id_bubble(bub7), .ifid_flush(iff7),
        .exmem_flush(exf7), .stall_count(sc7), .flush_count(fc7)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic mr, input logic rw,
                         input logic [4:0] rd, input logic br);
        id_valid     = v;
        id_rn        = rn;
        id_rm        = rm;
        id_uses_rn   = urn;
        id_uses_rm   = urm;
        id_mem_read  = mr;
        id_reg_write = rw;
        id_rd        = rd;
        branch_taken = br;
    endtask

    // Called at posedge+1: apply inputs, check mid-cycle, return at next posedge+1.
    task automatic cyc(input string tag, input logic v, input logic [4:0] rn,
                       input logic [4:0] rm, input logic urn, input logic urm,
                       input logic mr, input logic rw, input logic [4:0] rd,
                       input logic br, input logic [4:0] e1, input logic [4:0] e3);
        drive(v, rn, rm, urn, urm, mr, rw, rd, br);
        #3;
        check_eq({tag, "_s1"}, 32'(o1), 32'(e1));
        check_eq({tag, "_s3"}, 32'(o3), 32'(e3));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        #1;
        RESET = 1'b1;
        #1;
        // Outputs forced to idle while RESET is high, even with branch_taken.
        check_eq("rst_out_s1", 32'(o1), 32'(O_IDLE));
        check_eq("rst_out_s3", 32'(o3), 32'(O_IDLE));
        check_eq("rst_sc1", 32'(sc1), 32'd0);
        check_eq("rst_fc1", 32'(fc1), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        cyc("nop0", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);

        // LDUR X2 then use via rn: 1 stall on s1, 3 stalls on s3.
        cyc("a_ld",  1, 1, 0, 0, 0, 1, 1, 2, 0, O_IDLE,  O_IDLE);
        cyc("a_u1",  1, 2, 0, 1, 0, 0, 1, 3, 0, O_STALL, O_STALL);
        cyc("a_u2",  1, 2, 0, 1, 0, 0, 1, 3, 0, O_IDLE,  O_STALL);
        cyc("a_u3",  1, 2, 0, 1, 0, 0, 1, 3, 0, O_IDLE,  O_STALL);
        cyc("a_go",  1, 2, 0, 1, 0, 0, 1, 3, 0, O_IDLE,  O_IDLE);
        cyc("a_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_IDLE);

        // Load to XZR never hazards.
        cyc("b_ld",  1, 0, 0, 0, 0, 1, 1, 31, 0, O_IDLE, O_IDLE);
        cyc("b_use", 1, 31, 31, 1, 1, 0, 1, 4, 0, O_IDLE, O_IDLE);
        // Matching register but not read.
        cyc("c_ld",  1, 0, 0, 0, 0, 1, 1, 2, 0, O_IDLE, O_IDLE);
        cyc("c_use", 1, 2, 2, 0, 0, 0, 1, 4, 0, O_IDLE, O_IDLE);
        // memRead without regWrite is not a load.
        cyc("g_ld",  1, 0, 0, 0, 0, 1, 0, 6, 0, O_IDLE, O_IDLE);
        cyc("g_use", 1, 6, 0, 1, 0, 0, 1, 4, 0, O_IDLE, O_IDLE);
        // Invalid ID instruction does not stall.
        cyc("h_ld",  1, 0, 0, 0, 0, 1, 1, 7, 0, O_IDLE, O_IDLE);
        cyc("h_use", 0, 7, 0, 1, 0, 0, 1, 4, 0, O_IDLE, O_IDLE);

        // Load X5 then use via rm.
        cyc("d_ld",  1, 0, 0, 0, 0, 1, 1, 5, 0, O_IDLE,  O_IDLE);
        cyc("d_u1",  1, 0, 5, 0, 1, 0, 1, 3, 0, O_STALL, O_STALL);
        cyc("d_u2",  1, 0, 5, 0, 1, 0, 1, 3, 0, O_IDLE,  O_STALL);
        cyc("d_u3",  1, 0, 5, 0, 1, 0, 1, 3, 0, O_IDLE,  O_STALL);
        cyc("d_go",  1, 0, 5, 0, 1, 0, 1, 3, 0, O_IDLE,  O_IDLE);
        cyc("d_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  O_IDLE);

        // Branch in second stall cycle aborts the stall.
        cyc("e_ld",  1, 0, 0, 0, 0, 1, 1, 4, 0, O_IDLE,  O_IDLE);
        cyc("e_u1",  1, 4, 0, 1, 0, 0, 1, 3, 0, O_STALL, O_STALL);
        cyc("e_br",  1, 4, 0, 1, 0, 0, 1, 3, 1, O_FLUSH, O_FLUSH);
        cyc("e_u2",  1, 4, 0, 1, 0, 0, 1, 3, 0, O_IDLE,  O_IDLE);
        cyc("e_u3",  1, 4, 0, 1, 0, 0, 1, 3, 0, O_IDLE,  O_IDLE);

        // Branch beats hazard in the same cycle.
        cyc("f_ld",  1, 0, 0, 0, 0, 1, 1, 8, 0, O_IDLE,  O_IDLE);
        cyc("f_br",  1, 8, 0, 1, 0, 0, 1, 3, 1, O_FLUSH, O_FLUSH);
        cyc("f_use", 1, 8, 0, 1, 0, 0, 1, 3, 0, O_IDLE,  O_IDLE);

        // Reset mid-stall abandons the stall.
        cyc("r_ld",  1, 0, 0, 0, 0, 1, 1, 9, 0, O_IDLE,  O_IDLE);
        cyc("r_u1",  1, 9, 0, 1, 0, 0, 1, 3, 0, O_STALL, O_STALL);
        RESET = 1'b1;
        #3;
        check_eq("r_rst_s1", 32'(o1), 32'(O_IDLE));
        check_eq("r_rst_s3", 32'(o3), 32'(O_IDLE));
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc("r_u2",  1, 9, 0, 1, 0, 0, 1, 3, 0, O_IDLE, O_IDLE);
        cyc("r_u3",  1, 9, 0, 1, 0, 0, 1, 3, 0, O_IDLE, O_IDLE);
        check_eq("r_sc3", 32'(sc3), 32'd0);

        // Three taken branches.
        cyc("k_br1", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, O_FLUSH);
        cyc("k_br2", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, O_FLUSH);
        cyc("k_br3", 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, O_FLUSH);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        #3;
        check_eq("k_fc1", 32'(fc1), STATS ? 32'd3 : 32'd0);
        check_eq("k_fc3", 32'(fc3), STATS ? 32'd3 : 32'd0);
        check_eq("k_sc1", 32'(sc1), 32'd0);
        @(posedge CLK);
        #1;

`ifdef HAZARD_STATS_EN
        // Constant load-use pair: s7 stalls 7 of every 8 cycles.
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0);
        repeat (76000) @(posedge CLK);
        #1;
        check_eq("sat_sc7", 32'(sc7), 32'h0000FFFF);
        RESET = 1'b1;
        #3;
        check_eq("sat_rst_sc7", 32'(sc7), 32'd0);
        check_eq("sat_rst_fc1", 32'(fc1), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
`else
        check_eq("nostat_sc7", 32'(sc7), 32'd0);
        check_eq("nostat_out7", 32'(o7), 32'(O_IDLE));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
